// File: rtl/ram_fill_dump_ctrl.sv
// Fill/dump controller for a 16x8 single-port RAM with a one-cycle synchronous read.
// Optional RAM_FILL_DUMP_CLEAR_EN zeroes each RAM entry after it has been dumped.
module ram_fill_dump_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              dump_req,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic [DATA_W-1:0] ram_din,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr_en,
    input  logic [DATA_W-1:0] ram_out
);

`ifdef RAM_FILL_DUMP_CLEAR_EN
    typedef enum logic [2:0] {StIdle, StRdAddr, StRdWait, StOut, StClr} state_t;
`else
    typedef enum logic [1:0] {StIdle, StRdAddr, StRdWait, StOut} state_t;
`endif

    localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] One      = (ADDR_W + 1)'(1);

    state_t              state_q, state_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [ADDR_W-1:0]   rp_q, rp_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                last_entry;

    assign last_entry = ({1'b0, rp_q} == (count_q - One));
    assign count      = count_q;
    assign out_data   = out_data_q;
    assign busy       = (state_q != StIdle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            count_q    <= '0;
            rp_q       <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rp_q       <= rp_d;
            out_data_q <= out_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rp_d       = rp_q;
        out_data_d = out_data_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        ram_din    = '0;
        ram_addr   = '0;
        ram_wr_en  = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Gated by rst so no write can leak out while reset is held.
                in_ready = !rst && (count_q < DepthCnt) && !dump_req;
                if (dump_req && (count_q != '0)) begin
                    rp_d    = '0;
                    state_d = StRdAddr;
                end else if (in_valid && in_ready) begin
                    ram_addr  = count_q[ADDR_W-1:0];
                    ram_din   = in_data;
                    ram_wr_en = 1'b1;
                    count_d   = count_q + One;
                end
            end
            StRdAddr: begin
                ram_addr = rp_q;
                state_d  = StRdWait;
            end
            StRdWait: begin
                out_data_d = ram_out;
                state_d    = StOut;
            end
            StOut: begin
                out_valid = 1'b1;
                if (out_ready) begin
`ifdef RAM_FILL_DUMP_CLEAR_EN
                    state_d = StClr;
`else
                    if (last_entry) begin
                        count_d = '0;
                        state_d = StIdle;
                    end else begin
                        rp_d    = rp_q + 1'b1;
                        state_d = StRdAddr;
                    end
`endif
                end
            end
`ifdef RAM_FILL_DUMP_CLEAR_EN
            StClr: begin
                ram_addr  = rp_q;
                ram_wr_en = 1'b1;
                if (last_entry) begin
                    count_d = '0;
                    state_d = StIdle;
                end else begin
                    rp_d    = rp_q + 1'b1;
                    state_d = StRdAddr;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_ram_fill_dump_ctrl.sv
// Self-checking bench for ram_fill_dump_ctrl with a behavioural 16x8 synchronous-read RAM.
module tb_ram_fill_dump_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       dump_req = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [4:0] count;
    logic       busy;
    logic [7:0] ram_din;
    logic [3:0] ram_addr;
    logic       ram_wr_en;
    logic [7:0] ram_out;
    logic [7:0] mem [16];

    int checks = 0;
    int errors = 0;

`ifdef RAM_FILL_DUMP_CLEAR_EN
    localparam int PerByte = 4;
`else
    localparam int PerByte = 3;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_addr] <= ram_din;
        ram_out <= mem[ram_addr];
    end

    ram_fill_dump_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dump_req  (dump_req),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .busy      (busy),
        .ram_din   (ram_din),
        .ram_addr  (ram_addr),
        .ram_wr_en (ram_wr_en),
        .ram_out   (ram_out)
    );

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       dreq;
        logic       ir;
        logic       we;
        logic [3:0] addr;
        logic [7:0] din;
        logic [4:0] cnt;
        logic       bsy;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered in the RD_ADDR cycle that follows the edge which sampled dump_req.
    task automatic do_dump(input int n, input logic [7:0] exp [16], input int stall_byte);
        int         cyc;
        logic [7:0] held;
        #1;
        chk("rdaddr_busy", busy, 1);
        chk("rdaddr_addr", ram_addr, 0);
        chk("rdaddr_we", ram_wr_en, 0);
        chk("rdaddr_ovalid", out_valid, 0);
        for (int b = 0; b < n; b++) begin
            cyc = 0;
            while (!out_valid && cyc < 8) begin
                tick();
                cyc++;
            end
            chk("out_latency", cyc, (b == 0) ? 2 : PerByte - 1);
            chk("out_data", out_data, exp[b]);
            if (b == stall_byte) begin
                out_ready = 1'b0;
                held = out_data;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    chk("stall_valid", out_valid, 1);
                    chk("stall_data", out_data, held);
                    chk("stall_we", ram_wr_en, 0);
                end
                out_ready = 1'b1;
            end
            tick();
`ifdef RAM_FILL_DUMP_CLEAR_EN
            chk("clr_we", ram_wr_en, 1);
            chk("clr_addr", ram_addr, b);
            chk("clr_din", ram_din, 0);
`endif
        end
`ifdef RAM_FILL_DUMP_CLEAR_EN
        tick();
`endif
        chk("end_busy", busy, 0);
        chk("end_count", count, 0);
        chk("end_in_ready", in_ready, 1);
    endtask

    initial begin
        logic [7:0] exp [16];

        vecs[0] = '{iv: 1, d: 8'h11, dreq: 0, ir: 1, we: 1, addr: 0, din: 8'h11, cnt: 0, bsy: 0};
        vecs[1] = '{iv: 1, d: 8'h22, dreq: 0, ir: 1, we: 1, addr: 1, din: 8'h22, cnt: 1, bsy: 0};
        vecs[2] = '{iv: 1, d: 8'h33, dreq: 0, ir: 1, we: 1, addr: 2, din: 8'h33, cnt: 2, bsy: 0};
        vecs[3] = '{iv: 0, d: 8'h00, dreq: 0, ir: 1, we: 0, addr: 0, din: 8'h00, cnt: 3, bsy: 0};
        vecs[4] = '{iv: 1, d: 8'hAA, dreq: 1, ir: 0, we: 0, addr: 0, din: 8'h00, cnt: 3, bsy: 0};

        // Reset state
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_we", ram_wr_en, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_din", ram_din, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", in_ready, 1);

        // Fill of three bytes, then dump_req colliding with in_valid 0xAA
        for (int i = 0; i < 5; i++) begin
            in_valid = vecs[i].iv;
            in_data  = vecs[i].d;
            dump_req = vecs[i].dreq;
            #1;
            chk("vec_in_ready", in_ready, vecs[i].ir);
            chk("vec_we", ram_wr_en, vecs[i].we);
            if (vecs[i].we) begin
                chk("vec_addr", ram_addr, vecs[i].addr);
                chk("vec_din", ram_din, vecs[i].din);
            end
            chk("vec_count", count, vecs[i].cnt);
            chk("vec_busy", busy, vecs[i].bsy);
            tick();
        end
        in_valid = 1'b0;
        dump_req = 1'b0;
        chk("mem0", mem[0], 8'h11);
        chk("mem1", mem[1], 8'h22);
        chk("mem2", mem[2], 8'h33);
        chk("aa_not_stored", (mem[3] == 8'hAA), 0);

        exp[0] = 8'h11;
        exp[1] = 8'h22;
        exp[2] = 8'h33;
        do_dump(3, exp, -1);
`ifdef RAM_FILL_DUMP_CLEAR_EN
        for (int i = 0; i < 3; i++) chk("cleared", mem[i], 0);
`else
        chk("persist2", mem[2], 8'h33);
`endif

        // dump_req with an empty store is ignored
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        #1;
        chk("empty_dump_busy", busy, 0);

        // Fill to full, then offer 0xFF
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            #1;
            chk("fill_in_ready", in_ready, 1);
            tick();
        end
        in_data = 8'hFF;
        #1;
        chk("full_in_ready", in_ready, 0);
        chk("full_count", count, 16);
        chk("full_we", ram_wr_en, 0);
        tick();
        in_valid = 1'b0;
        chk("full_count2", count, 16);
        chk("full_mem0", mem[0], 8'h00);
        chk("full_mem15", mem[15], 8'h0F);

        // Full dump with a 5-cycle out_ready stall on the second byte
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        for (int i = 0; i < 16; i++) exp[i] = 8'(i);
        do_dump(16, exp, 1);
`ifdef RAM_FILL_DUMP_CLEAR_EN
        for (int i = 0; i < 16; i++) chk("cleared_full", mem[i], 0);
`endif

        // Reset asserted while the first dump byte is pending
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = (i == 0) ? 8'h5A : 8'hA5;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dump_req  = 1'b1;
        tick();
        dump_req = 1'b0;
        tick();
        tick();
        chk("mid_out_valid", out_valid, 1);
        chk("mid_out_data", out_data, 8'h5A);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_we", ram_wr_en, 0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("after_rst_in_ready", in_ready, 1);
        chk("after_rst_mem0", mem[0], 8'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
